// File: rtl/wb_trace_collector_if.sv
// Architectural-write taps in, ordered event stream out; the master modport is the collector side.
// Occupancy and the sticky drop flag travel with the stream so the judger can observe them.
interface wb_trace_collector_if #(
  parameter int AW = 4
);
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_kind;
  logic [31:0] evt_pc;
  logic [31:0] evt_addr;
  logic [31:0] evt_data;
  logic [AW:0] count;
  logic        overflow;

  modport master (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  evt_ready,
    output evt_valid, evt_kind, evt_pc, evt_addr, evt_data,
    output count, overflow
  );

  modport slave (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output evt_ready,
    input  evt_valid, evt_kind, evt_pc, evt_addr, evt_data,
    input  count, overflow
  );
endinterface

// File: rtl/wb_trace_collector.sv
// Queues GRF/DM write events (GRF first) and streams them out FWFT, 1-cycle latency, held while stalled.
// Full FIFO drops newest events and sets a sticky overflow; WB_TRACE_DISPLAY_EN adds a $display trace.
module wb_trace_collector #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                   clk,
  input logic                   reset,
  wb_trace_collector_if.master  bus
);

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } evt_t;

  evt_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          head_vld;
  evt_t          head;

  logic          grf_ev;
  logic          dm_ev;
  evt_t          grf_e;
  evt_t          dm_e;
  evt_t          e0;
  evt_t          e1;
  logic [1:0]    n_evt;
  logic          pop;
  logic          push0;
  logic          push1;
  logic          drop;
  logic [AW+1:0] free;
  logic [AW-1:0] wr_ptr_p1;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW:0]   count_nxt;
  evt_t          head_nxt;

  always_comb begin
    grf_ev = bus.grf_we && (bus.grf_addr != 5'd0);
    dm_ev  = bus.dm_we;
    grf_e  = {1'b0, bus.grf_pc, {27'd0, bus.grf_addr}, bus.grf_wdata};
    dm_e   = {1'b1, bus.dm_pc, bus.dm_addr, bus.dm_wdata};

    // Slot 0 holds the older event; slot 1 is only ever the DM of a dual-event cycle.
    e0    = grf_ev ? grf_e : dm_e;
    e1    = dm_e;
    n_evt = {1'b0, grf_ev} + {1'b0, dm_ev};

    pop   = head_vld && bus.evt_ready;
    free  = (AW+2)'(DEPTH) - {1'b0, count} + (AW+2)'(pop);
    push0 = (n_evt != 2'd0) && (free != '0);
    push1 = (n_evt == 2'd2) && (free >= (AW+2)'(2));
    drop  = (n_evt != ({1'b0, push0} + {1'b0, push1}));

    wr_ptr_p1  = wr_ptr + 1'b1;
    rd_ptr_nxt = rd_ptr + AW'(pop);
    wr_ptr_nxt = wr_ptr + AW'(push0) + AW'(push1);
    count_nxt  = count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);

    // The next head can only be a fresh write when the queue drains to nothing this cycle,
    // and then it is always slot 0, so one bypass path suffices.
    head_nxt = mem[rd_ptr_nxt];
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (push0 && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = e0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      rd_ptr   <= rd_ptr_nxt;
      wr_ptr   <= wr_ptr_nxt;
      count    <= count_nxt;
      head_vld <= (count_nxt != '0);
      head     <= head_nxt;
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push0) begin
        mem[wr_ptr] <= e0;
      end
      if (push1) begin
        mem[wr_ptr_p1] <= e1;
      end
    end
  end

  assign bus.evt_valid = head_vld;
  assign bus.evt_kind  = head.kind;
  assign bus.evt_pc    = head.pc;
  assign bus.evt_addr  = head.addr;
  assign bus.evt_data  = head.data;
  assign bus.count     = count;
  assign bus.overflow  = overflow;

`ifdef WB_TRACE_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (push0) begin
        if (!e0.kind) $display("@%h: $%d <= %h", e0.pc, e0.addr[4:0], e0.data);
        else          $display("@%h: *%h <= %h", e0.pc, e0.addr, e0.data);
      end
      if (push1) begin
        $display("@%h: *%h <= %h", e1.pc, e1.addr, e1.data);
      end
      if (grf_ev && !push0) begin
        $display("TRACE OVERFLOW @%h", bus.grf_pc);
      end
      if (dm_ev && !(grf_ev ? push1 : push0)) begin
        $display("TRACE OVERFLOW @%h", bus.dm_pc);
      end
    end
  end
`else
  // Silent build: the datapath above is identical either way.
`endif

endmodule

// File: tb/tb_wb_trace_collector.sv
// Directed stimulus with a scoreboard queue of expected events and a negedge monitor that pops on handshakes.
module tb_wb_trace_collector;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  ev_t  exp_q[$];

  wb_trace_collector_if #(.AW(4)) bus ();

  wb_trace_collector #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.grf_we    = 1'b0;
    bus.grf_pc    = '0;
    bus.grf_addr  = '0;
    bus.grf_wdata = '0;
    bus.dm_we     = 1'b0;
    bus.dm_pc     = '0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
  endtask

  task automatic grf(input logic [31:0] pc, input logic [4:0] r, input logic [31:0] d, input bit exp);
    bus.grf_we    = 1'b1;
    bus.grf_pc    = pc;
    bus.grf_addr  = r;
    bus.grf_wdata = d;
    if (exp) exp_q.push_back({1'b0, pc, {27'd0, r}, d});
  endtask

  task automatic dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d, input bit exp);
    bus.dm_we    = 1'b1;
    bus.dm_pc    = pc;
    bus.dm_addr  = a;
    bus.dm_wdata = d;
    if (exp) exp_q.push_back({1'b1, pc, a, d});
  endtask

  // Monitor: compares every accepted head against the scoreboard and checks hold-under-stall.
  initial begin
    ev_t cur;
    ev_t prev;
    ev_t want;
    bit  stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {bus.evt_kind, bus.evt_pc, bus.evt_addr, bus.evt_data};
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && bus.evt_valid) check("stall_hold", cur, prev);
        if (bus.evt_valid && bus.evt_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_evt: actual=%0h required=none", cur);
          end else begin
            want = exp_q.pop_front();
            check("evt", cur, want);
          end
        end
        stall_prev = bus.evt_valid && !bus.evt_ready;
        prev = cur;
      end
    end
  end

  initial begin
    int n;
    checks = 0;
    failures = 0;
    clr();
    bus.evt_ready = 1'b0;
    reset = 1'b1;

    // Reset held two cycles.
    tick();
    tick();
    check("rst_valid", bus.evt_valid, 1'b0);
    check("rst_count", bus.count, 5'd0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_data", {bus.evt_kind, bus.evt_pc, bus.evt_addr, bus.evt_data}, '0);
    reset = 1'b0;
    tick();

    // Single GRF event, visible one edge later, then empty.
    bus.evt_ready = 1'b1;
    grf(32'h3000, 5'd8, 32'h1234, 1'b1);
    tick();
    clr();
    check("single_valid", bus.evt_valid, 1'b1);
    check("single_addr", bus.evt_addr, 32'd8);
    tick();
    check("single_empty_valid", bus.evt_valid, 1'b0);
    check("single_empty_count", bus.count, 5'd0);

    // Same-cycle GRF + DM: GRF is the head.
    bus.evt_ready = 1'b0;
    grf(32'h3004, 5'd9, 32'hAAAA0009, 1'b1);
    dm(32'h3008, 32'h10, 32'd5, 1'b1);
    tick();
    clr();
    check("dual_count", bus.count, 5'd2);
    check("dual_head_kind", bus.evt_kind, 1'b0);
    tick();
    check("dual_stall_count", bus.count, 5'd2);
    bus.evt_ready = 1'b1;
    tick();
    tick();
    check("dual_drained", bus.count, 5'd0);

    // $0 writes are filtered; with a same-cycle DM only the DM survives.
    grf(32'h300c, 5'd0, 32'hDEAD, 1'b0);
    tick();
    clr();
    check("zero_count", bus.count, 5'd0);
    check("zero_overflow", bus.overflow, 1'b0);
    check("zero_valid", bus.evt_valid, 1'b0);
    bus.evt_ready = 1'b0;
    grf(32'h3010, 5'd0, 32'hBEEF, 1'b0);
    dm(32'h3014, 32'h20, 32'h77, 1'b1);
    tick();
    clr();
    check("zero_dm_count", bus.count, 5'd1);
    check("zero_dm_kind", bus.evt_kind, 1'b1);
    bus.evt_ready = 1'b1;
    tick();
    check("zero_dm_drained", bus.count, 5'd0);

    // Fill to 16, drop the 17th, then push+pop at full.
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dm(32'h4000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'(i * 32'h11), 1'b1);
      tick();
    end
    clr();
    check("full_count", bus.count, 5'd16);
    check("full_no_overflow", bus.overflow, 1'b0);
    dm(32'h5000, 32'h180, 32'hFF, 1'b0);
    tick();
    clr();
    check("drop_count", bus.count, 5'd16);
    check("drop_overflow", bus.overflow, 1'b1);
    check("drop_head_pc", bus.evt_pc, 32'h4000);
    bus.evt_ready = 1'b1;
    grf(32'h5004, 5'd3, 32'h33, 1'b1);
    tick();
    clr();
    check("full_pushpop_count", bus.count, 5'd16);
    // One free slot (via the pop) with two events: GRF kept, DM dropped.
    grf(32'h5008, 5'd4, 32'h44, 1'b1);
    dm(32'h500c, 32'h200, 32'h55, 1'b0);
    tick();
    clr();
    check("free1_count", bus.count, 5'd16);
    n = 0;
    while (bus.count != 0 && n < 40) begin
      tick();
      n++;
    end
    check("fill_drained", bus.count, 5'd0);

    // Wrap: 40 events with ready low every fourth cycle.
    for (int i = 0; i < 40; i++) begin
      bus.evt_ready = (i % 4) != 0;
      if (i % 2 == 0) grf(32'h6000 + 32'(4 * i), 5'((i % 31) + 1), 32'hC0DE0000 + 32'(i), 1'b1);
      else            dm(32'h6000 + 32'(4 * i), 32'h400 + 32'(4 * i), 32'hD0000000 + 32'(i), 1'b1);
      tick();
      clr();
    end

    // Reset mid-stream discards everything queued.
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_valid", bus.evt_valid, 1'b0);
    check("midrst_count", bus.count, 5'd0);
    check("midrst_overflow", bus.overflow, 1'b0);
    check("midrst_data", bus.evt_data, 32'd0);
    reset = 1'b0;
    bus.evt_ready = 1'b1;
    grf(32'h7000, 5'd31, 32'h7777, 1'b1);
    tick();
    clr();
    check("post_rst_valid", bus.evt_valid, 1'b1);
    tick();
    tick();
    check("post_rst_count", bus.count, 5'd0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
